// File: rtl/network_div_seq_28s_12s_16_if.sv
// Handshake/bus bundle for the 28s / 12s -> 16s sequential divider.
// master: operand producer and result consumer (drives in_valid, dividend,
//         divisor, out_ready).
// slave:  the divider (drives in_ready, out_valid, quotient, remainder, sat,
//         div_zero).
interface network_div_seq_28s_12s_16_if #(
  parameter int unsigned DIVIDEND_WIDTH = 28,
  parameter int unsigned DIVISOR_WIDTH  = 12,
  parameter int unsigned QUOTIENT_WIDTH = 16
);
  logic                             in_valid;
  logic                             in_ready;
  logic signed [DIVIDEND_WIDTH-1:0] dividend;
  logic signed [DIVISOR_WIDTH-1:0]  divisor;
  logic                             out_valid;
  logic                             out_ready;
  logic signed [QUOTIENT_WIDTH-1:0] quotient;
  logic signed [DIVISOR_WIDTH-1:0]  remainder;
  logic                             sat;
  logic                             div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, sat, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, sat, div_zero
  );
endinterface

// File: rtl/network_div_seq_28s_12s_16.sv
// Radix-2 restoring signed divider: 28-bit signed dividend / 12-bit signed
// divisor -> saturated 16-bit signed quotient (truncated toward zero) and
// 12-bit signed remainder (sign of the dividend). One quotient bit per
// enabled cycle; result presented 29 enabled edges after acceptance.
// Ports:
//   clk     - clock, rising edge
//   reset_n - synchronous active-low reset
//   ce      - clock enable; all state holds while low
//   bus     - slave side of the operand/result handshake bundle
module network_div_seq_28s_12s_16 #(
  parameter int unsigned DIVIDEND_WIDTH = 28,
  parameter int unsigned DIVISOR_WIDTH  = 12,
  parameter int unsigned QUOTIENT_WIDTH = 16
) (
  input logic                           clk,
  input logic                           reset_n,
  input logic                           ce,
  network_div_seq_28s_12s_16_if.slave   bus
);

  localparam int unsigned DW = DIVIDEND_WIDTH;
  localparam int unsigned VW = DIVISOR_WIDTH;
  localparam int unsigned QW = QUOTIENT_WIDTH;
  localparam int unsigned CW = $clog2(DW);

  localparam logic [CW-1:0] CNT_LOAD  = CW'(DW - 1);
  localparam logic [DW-1:0] QPOS_LIM  = DW'((64'd1 << (QW - 1)) - 64'd1);
  localparam logic [DW-1:0] QNEG_LIM  = DW'(64'd1 << (QW - 1));
  localparam logic [QW-1:0] QMAX      = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] QMIN      = {1'b1, {(QW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t        state, state_nxt;

  // dvd_q shifts dividend magnitude out at the top while quotient bits enter
  // at the bottom; after the last step it holds the quotient magnitude.
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [VW-1:0] rem_q;
  logic          sgn_a_q, sgn_b_q, zero_q;
  logic [CW-1:0] cnt_q;

  logic          in_ready_d, out_valid_d;
  logic [QW-1:0] q_fix;
  logic [VW-1:0] r_fix;
  logic          sat_fix;

  logic [VW:0]   trial, diff;
  logic          take;
  logic [VW-1:0] rem_nxt;
  logic [DW-1:0] dvd_abs;
  logic [VW-1:0] dvs_abs;

  // Operand magnitudes; the most negative values map onto 2^(W-1) unsigned.
  assign dvd_abs = bus.dividend[DW-1] ? (~bus.dividend + DW'(1)) : bus.dividend;
  assign dvs_abs = bus.divisor[VW-1]  ? (~bus.divisor  + VW'(1)) : bus.divisor;

  // One restoring step. rem_q < dvs_q always holds, so the difference fits
  // back into VW bits (except divide-by-zero, whose result is overridden).
  assign trial   = {rem_q, dvd_q[DW-1]};
  assign diff    = trial - {1'b0, dvs_q};
  assign take    = (trial >= {1'b0, dvs_q});
  assign rem_nxt = take ? diff[VW-1:0] : trial[VW-1:0];

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else if (ce) begin
      state         <= state_nxt;
      bus.in_ready  <= in_ready_d;
      bus.out_valid <= out_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = BUSY;
      BUSY:    if (cnt_q == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: handshake levels for the next state and the signed,
  // saturated result formed in FIX.
  always_comb begin
    in_ready_d  = (state_nxt == IDLE);
    out_valid_d = (state_nxt == DONE);
    q_fix       = dvd_q[QW-1:0];
    sat_fix     = 1'b0;
    r_fix       = sgn_a_q ? (~rem_q + VW'(1)) : rem_q;
    if (zero_q) begin
      q_fix   = sgn_a_q ? QMIN : QMAX;
      sat_fix = 1'b1;
      r_fix   = '0;
    end else if (sgn_a_q ^ sgn_b_q) begin
      if (dvd_q > QNEG_LIM) begin
        q_fix   = QMIN;
        sat_fix = 1'b1;
      end else begin
        q_fix = ~dvd_q[QW-1:0] + QW'(1);
      end
    end else if (dvd_q > QPOS_LIM) begin
      q_fix   = QMAX;
      sat_fix = 1'b1;
    end
  end

  // Datapath: operand capture, iteration, result registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      sgn_a_q       <= 1'b0;
      sgn_b_q       <= 1'b0;
      zero_q        <= 1'b0;
      cnt_q         <= '0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.sat       <= 1'b0;
      bus.div_zero  <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dvd_q   <= dvd_abs;
            dvs_q   <= dvs_abs;
            rem_q   <= '0;
            sgn_a_q <= bus.dividend[DW-1];
            sgn_b_q <= bus.divisor[VW-1];
            zero_q  <= (bus.divisor == '0);
            cnt_q   <= CNT_LOAD;
          end
        end
        BUSY: begin
          rem_q <= rem_nxt;
          dvd_q <= {dvd_q[DW-2:0], take};
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        FIX: begin
          bus.quotient  <= q_fix;
          bus.remainder <= r_fix;
          bus.sat       <= sat_fix;
          bus.div_zero  <= zero_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_network_div_seq_28s_12s_16.sv
// Directed self-checking bench for network_div_seq_28s_12s_16.
module tb_network_div_seq_28s_12s_16;

  logic clk = 1'b0;
  logic reset_n;
  logic ce;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  network_div_seq_28s_12s_16_if bus ();

  network_div_seq_28s_12s_16 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .bus     (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int eq, input int er,
                               input int esat, input int edz);
    int q, r;
    q = $signed(bus.quotient);
    r = $signed(bus.remainder);
    check({tag, " q"},   q, eq);
    check({tag, " r"},   r, er);
    check({tag, " sat"}, int'(bus.sat), esat);
    check({tag, " dz"},  int'(bus.div_zero), edz);
  endtask

  // Accept an operation and return once it is accepted (edge 0 just passed).
  task automatic accept(input string tag, input int a, input int b);
    check({tag, " rdy"}, int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 28'(a);
    bus.divisor  = 12'(b);
    @(posedge clk);
    #1;
    check({tag, " busy"}, int'(bus.in_ready), 0);
  endtask

  // One full operation: accept, optional ce gap, optional DONE hold, handshake.
  task automatic run_div(input string tag, input int a, input int b,
                         input int eq, input int er, input int esat, input int edz,
                         input int gap_at, input int hold, input int elat);
    int lat;
    int q0;
    accept(tag, a, b);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      // Operands change while busy; the result must not care.
      bus.dividend = 28'h5A5A5A5;
      bus.divisor  = 12'h3C3;
      ce = !(gap_at >= 0 && lat >= gap_at && lat < gap_at + 5);
      @(posedge clk);
      #1;
      lat++;
    end
    ce = 1'b1;
    check({tag, " lat"}, lat, elat);
    check_outputs(tag, eq, er, esat, edz);
    if (hold > 0) begin
      q0 = $signed(bus.quotient);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        bus.in_valid = ~bus.in_valid;
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({tag, " hold vld"}, int'(bus.out_valid), 1);
      check({tag, " hold rdy"}, int'(bus.in_ready), 0);
      check({tag, " hold q"}, int'($signed(bus.quotient)), q0);
      check_outputs({tag, " hold"}, eq, er, esat, edz);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " post vld"}, int'(bus.out_valid), 0);
    check({tag, " post rdy"}, int'(bus.in_ready), 1);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    ce            = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst rdy", int'(bus.in_ready), 1);
    check("rst vld", int'(bus.out_valid), 0);
    check_outputs("rst", 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic, with a 10-cycle stall in DONE.
    run_div("p1000/7",   1000,  7,  142,  6, 0, 0, -1, 10, 29);
    // Sign handling.
    run_div("n1000/7",  -1000,  7, -142, -6, 0, 0, -1, 0, 29);
    run_div("p1000/n7",  1000, -7, -142,  6, 0, 0, -1, 0, 29);
    run_div("n1000/n7", -1000, -7,  142, -6, 0, 0, -1, 0, 29);
    run_div("n2048/n2048", -2048, -2048, 1, 0, 0, 0, -1, 0, 29);
    // Saturation boundaries.
    run_div("maxpos/1", 134217727, 1,  32767, 0, 1, 0, -1, 0, 29);
    run_div("maxneg/1", -134217728, 1, -32768, 0, 1, 0, -1, 0, 29);
    run_div("n32768/1", -32768, 1, -32768, 0, 0, 0, -1, 0, 29);
    run_div("65536/n2", 65536, -2, -32768, 0, 0, 0, -1, 0, 29);
    run_div("65538/n2", 65538, -2, -32768, 0, 1, 0, -1, 0, 29);
    run_div("0/5",      0, 5, 0, 0, 0, 0, -1, 0, 29);
    // ce gap mid-iteration.
    run_div("ce gap",   1000, 7, 142, 6, 0, 0, 10, 0, 34);
    // Divide by zero (leaves sat/div_zero set for the reset check below).
    run_div("-5/0",    -5, 0, -32768, 0, 1, 1, -1, 0, 29);
    run_div("5/0",      5, 0,  32767, 0, 1, 1, -1, 0, 29);

    // Reset during iteration 12.
    accept("rst mid", 1000, 7);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (11) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst mid rdy", int'(bus.in_ready), 1);
    check("rst mid vld", int'(bus.out_valid), 0);
    check_outputs("rst mid", 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_div("after rst", 1000, 7, 142, 6, 0, 0, -1, 0, 29);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/network_div_seq_28s_12s_16.md
Name: network_div_seq_28s_12s_16

Overview:
- Iterative signed divider, the inverse of the 16s x 12s -> 28s pipelined DSP multiplier in the network datapath.
- Takes a 28-bit signed wide product/accumulator value and a 12-bit signed scale, then returns a saturated 16-bit signed quotient and a 12-bit signed remainder.
- Used for requantising layer outputs back to 16-bit activations.
- Radix-2, one quotient bit per enabled cycle, with valid/ready handshakes on both sides and a clock enable matching the multiplier cores.

Parameters:
- DIVIDEND_WIDTH, 28, signed dividend width.
- DIVISOR_WIDTH, 12, signed divisor width; also the remainder width.
- QUOTIENT_WIDTH, 16, signed saturated quotient width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  synchronous reset, active-low.
- ce  input  1  clock enable; when low, all state and outputs hold and no handshake completes.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- dividend  input  DIVIDEND_WIDTH  signed numerator.
- divisor  input  DIVISOR_WIDTH  signed denominator.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  QUOTIENT_WIDTH  signed quotient, truncated toward zero, saturated.
- remainder  output  DIVISOR_WIDTH  signed remainder; its sign follows the dividend.
- sat  output  1  quotient was clipped.
- div_zero  output  1  divisor was zero.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is clk, reset port is reset_n.
- Reset, sampled on a clk edge with reset_n=0, regardless of state or ce:
  - state=IDLE, so in_ready=1;
  - out_valid=0;
  - quotient=0, remainder=0, sat=0, div_zero=0;
  - iteration counter=0.
- An in-flight operation is discarded on reset.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0.
  - FIX: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Transitions (only evaluated on edges with ce=1):
  - IDLE -> BUSY on in_valid & in_ready. Latch |dividend| (28-bit unsigned; 2^27 is representable), |divisor| (12-bit unsigned; 2048 is representable), both sign bits, and divisor==0. Clear the partial remainder and load the counter with DIVIDEND_WIDTH-1.
  - BUSY: each enabled cycle performs one restoring shift-subtract step, producing one quotient magnitude bit MSB-first. When counter==0 -> FIX; otherwise decrement the counter.
  - FIX: single cycle. Apply the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign). Saturate and register the outputs. Go to DONE.
  - DONE: outputs held stable until out_valid & out_ready with ce=1, then -> IDLE.
- No input acceptance in the same cycle as the output handshake; back-to-back throughput is one result per 31 enabled cycles minimum.
- Latency: the accept edge is edge 0. The FIX edge is edge 29, so out_valid is high after DIVIDEND_WIDTH+1 = 29 enabled edges. Every ce=0 cycle extends latency by one.
- Saturation:
  - true quotient > 2^(QW-1)-1 -> 32767, sat=1;
  - true quotient < -2^(QW-1) -> -32768, sat=1;
  - remainder is always exact, since |r| <= 2047.
- Divide by zero: div_zero=1, sat=1, remainder=0. Quotient is 32767 if dividend >= 0, otherwise -32768. The iterations still run, so latency is unchanged.
- Zero dividend: quotient=0, remainder=0, sat=0.
- Operands are sampled only at acceptance; dividend/divisor changes while BUSY have no effect.
- Flags sat and div_zero are valid only while out_valid=1. They hold their last value in IDLE until the next FIX.

Test Plan:
- 1000 / 7, ce=1, out_ready=1 -> out_valid high 29 edges after accept; quotient=142, remainder=6, sat=0, div_zero=0; in_ready returns 1 one edge after the output handshake.
- Sign cases:
  - -1000/7 -> q=-142, r=-6;
  - 1000/-7 -> q=-142, r=6;
  - -1000/-7 -> q=142, r=-6;
  - -2048/-2048 -> q=1, r=0.
- Saturation:
  - 134217727/1 -> q=32767, sat=1;
  - -134217728/1 -> q=-32768, sat=1;
  - -32768/1 -> q=-32768, sat=0;
  - 65536/-2 -> q=-32768, sat=0;
  - 65538/-2 -> q=-32768, sat=1.
- Divide by zero: 5/0 -> q=32767, r=0, div_zero=1, sat=1; -5/0 -> q=-32768; latency still 29 edges.
- Flow control:
  - out_ready=0 for 10 cycles in DONE -> outputs and out_valid stable, in_ready=0, in_valid pulses ignored.
  - ce=0 for 5 cycles mid-BUSY -> result unchanged, out_valid delayed to 34 edges after accept.
- Reset mid-operation: reset_n=0 for one edge at iteration 12 -> next cycle in_ready=1, out_valid=0, outputs 0; a fresh 1000/7 afterwards yields 142/6 with normal latency.
